pcie_cq_tx_fifo: RTL and testbench
==================================

# pcie_cq_tx_fifo

Store-and-forward transmit buffer on the PCIe TX path, the transmit-side counterpart of the SQ receive FIFO. Upstream completion/DMA logic pushes payload beats and marks packet ends; the TLP transmit engine sees a packet, with its beat count for header construction, only once the whole packet is buffered, so a memory-write TLP cannot underrun mid-packet. Beats leave through a valid/ready stream at one beat per cycle.

## Interface
- P_FIFO_DATA_WIDTH, 128, beat width in bits
- P_FIFO_DEPTH_WIDTH, 5, log2 of data-queue depth in beats (32)
- P_PKT_DEPTH_WIDTH, 2, log2 of length-queue depth in packets (4)

Ports:
- clk  in  1  clock; all logic is rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  push one beat; honoured only when full_n=1
- wr_data  in  P_FIFO_DATA_WIDTH  beat payload
- wr_last  in  1  qualifies wr_en; the beat closes (commits) the current packet
- full_n  out  1  high when at least one beat slot is free and the length queue is not full
- pkt_avail  out  1  at least one committed packet is present (length queue non-empty)
- pkt_len  out  P_FIFO_DEPTH_WIDTH+1  beat count of the head packet; valid while pkt_avail=1
- rd_valid  out  1  output beat valid
- rd_ready  in  1  consumer accepts the beat
- rd_data  out  P_FIFO_DATA_WIDTH  output beat
- rd_last  out  1  output beat is the last beat of the head packet
- ovf_err  out  1  sticky: wr_en seen while full_n=0, or a packet exceeded 2^P_FIFO_DEPTH_WIDTH beats

## Operation
- Data queue: inferred simple dual-port RAM, 2^D entries, synchronous read, no vendor macros.
- Pointers are D+1 bits (wrap bit plus index): wr_ptr, commit_ptr, rd_ptr (memory read issue), free_ptr.
- Occupancy = wr_ptr − free_ptr, computed modulo 2^(D+1). full_n = (occupancy < 2^D) && length queue not full. The length queue is full when it holds 2^P packets, or when it holds 2^P−1 packets and a closing beat is in flight.
- Write: on wr_en&&full_n, write the beat at wr_ptr[D-1:0], increment wr_ptr, and increment the open-packet beat counter. If wr_last is also set, push the count (including this beat) into the length queue, set commit_ptr to the new wr_ptr, and clear the counter.
- Read issue: the RAM is read at rd_ptr only when rd_ptr≠commit_ptr and the 2-entry output skid buffer has room after accounting for the read already in flight. Uncommitted beats are never read.
- Output: the skid buffer head drives rd_data/rd_valid. A handshake (rd_valid&&rd_ready) increments free_ptr and the head-packet beat index. rd_last = (index == pkt_len−1). A handshake with rd_last pops the length queue and resets the index.
- rd_data, rd_last and rd_valid hold steady while rd_valid&&!rd_ready.
- A single-beat packet has pkt_len=1 and rd_last on its only beat.
- Boundary behaviour:
  - wr_en while full_n=0: the beat is dropped and ovf_err is set.
  - Open-packet counter reaching 2^D: sets ovf_err. Writers must keep packets to 2^D beats or fewer.
  - A write and a read handshake in the same cycle both take effect. Occupancy is unchanged.
  - Pointer wrap is handled by the wrap bit. Full = index equal and wrap bits differ; empty = pointers equal.

## Timing
- Reset values: full_n=1, pkt_avail=0, pkt_len=0, rd_valid=0, rd_data=0, rd_last=0, ovf_err=0. All pointers, counters, queues and skid entries are cleared.
- Reset mid-operation discards every stored beat, including any partial packet, and restarts from empty.
- Closing beat accepted at edge N:
  - pkt_avail=1 and pkt_len valid after edge N.
  - First RAM read issued in cycle N+1.
  - rd_valid=1 after edge N+2 (commit-to-output latency 2 cycles).
- Throughput: with rd_ready held at 1, one beat per cycle sustained across packet boundaries, with no bubble between back-to-back committed packets.
- full_n is combinational from registered state only, never from wr_en. A freed slot raises full_n in the cycle after the handshake edge.

## Configuration
- PCIE_CQ_TX_FIFO_ERR_EN defined: ovf_err is implemented as specified (sticky until reset).
- Not defined: ovf_err is tied to 0 and its detection logic is omitted. Dropping of beats written while full_n=0 is unchanged.

## Test plan
- After reset, write 3 beats (0xA,0xB,0xC, last on 0xC) with rd_ready=1. Required: pkt_avail=1 and pkt_len=3 one cycle after the last write; rd_valid two cycles after; data A,B,C on consecutive cycles with rd_last only on C; pkt_avail=0 after C.
- Write 2 beats without wr_last. Required: pkt_avail=0 and rd_valid=0 indefinitely. Then a 3rd beat with wr_last. Required: pkt_len=3, all beats delivered.
- Fill 32 beats as one packet with rd_ready=0. Required: full_n=0 after the 32nd beat. A 33rd wr_en is dropped and ovf_err=1. Drain 1 beat; full_n=1 the next cycle.
- Four 1-beat packets with rd_ready=0. Required: full_n=0 (length queue full). Then rd_ready=1: four beats on 4 consecutive cycles, each with rd_last=1 and pkt_len=1.
- Run 100 random-length packets (1–8 beats) with random rd_ready so pointers wrap several times. Required: output equals input in order, rd_last correct, no ovf_err.
- Assert rst_n mid-packet during output. Required: all outputs return to reset values immediately; subsequent traffic starts from an empty FIFO.

Source files
------------

// File: rtl/pcie_cq_tx_fifo_if.sv
// Push/pop bundle for the PCIe CQ transmit FIFO: beat write side with packet
// commit, packet-length status, and the valid/ready beat output stream.
interface pcie_cq_tx_fifo_if #(
  parameter int P_FIFO_DATA_WIDTH  = 128,
  parameter int P_FIFO_DEPTH_WIDTH = 5
);
  logic                          wr_en;
  logic [P_FIFO_DATA_WIDTH-1:0]  wr_data;
  logic                          wr_last;
  logic                          full_n;
  logic                          pkt_avail;
  logic [P_FIFO_DEPTH_WIDTH:0]   pkt_len;
  logic                          rd_valid;
  logic                          rd_ready;
  logic [P_FIFO_DATA_WIDTH-1:0]  rd_data;
  logic                          rd_last;
  logic                          ovf_err;

  modport master (
    output wr_en, wr_data, wr_last, rd_ready,
    input  full_n, pkt_avail, pkt_len, rd_valid, rd_data, rd_last, ovf_err
  );

  modport slave (
    input  wr_en, wr_data, wr_last, rd_ready,
    output full_n, pkt_avail, pkt_len, rd_valid, rd_data, rd_last, ovf_err
  );
endinterface

// File: rtl/pcie_cq_tx_fifo.sv
// Store-and-forward TX beat FIFO: packets become visible only once committed.
// Define PCIE_CQ_TX_FIFO_ERR_EN to build the sticky ovf_err detector.
module pcie_cq_tx_fifo #(
  parameter int P_FIFO_DATA_WIDTH  = 128,
  parameter int P_FIFO_DEPTH_WIDTH = 5,
  parameter int P_PKT_DEPTH_WIDTH  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  pcie_cq_tx_fifo_if.slave bus
);
  localparam int DW    = P_FIFO_DATA_WIDTH;
  localparam int D     = P_FIFO_DEPTH_WIDTH;
  localparam int P     = P_PKT_DEPTH_WIDTH;
  localparam int DEPTH = 1 << D;
  localparam int PKTS  = 1 << P;
  localparam logic [D:0] PTR_ONE = (D+1)'(1);
  localparam logic [P:0] LQ_ONE  = (P+1)'(1);

  logic [D:0]    wr_ptr, commit_ptr, rd_ptr, free_ptr, occupancy;
  logic [D:0]    open_cnt, open_cnt_next;
  logic [P:0]    lq_wr_ptr, lq_rd_ptr, lq_cnt;
  logic [D:0]    lq_mem [PKTS];
  logic          lq_full, full_n, wr_fire;
  logic [DW-1:0] mem [DEPTH];
  logic          rd_issue_p0;
  logic [DW-1:0] ram_q_p1;
  logic          inflight_p1;
  logic [DW-1:0] skid_data_p2 [2];
  logic [1:0]    skid_cnt_p2, skid_cnt_next;
  logic          rd_valid, rd_hs, rd_last, pkt_avail;
  logic [D:0]    pkt_len, beat_idx;

  // Commit happens on the closing-beat edge itself, so a full count is the only stop.
  assign occupancy     = wr_ptr - free_ptr;
  assign lq_cnt        = lq_wr_ptr - lq_rd_ptr;
  assign lq_full       = lq_cnt[P];
  assign full_n        = ~occupancy[D] & ~lq_full;
  assign wr_fire       = bus.wr_en & full_n;
  assign open_cnt_next = open_cnt + PTR_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      open_cnt   <= '0;
      lq_wr_ptr  <= '0;
      for (int i = 0; i < PKTS; i++) lq_mem[i] <= '0;
    end else if (wr_fire) begin
      wr_ptr <= wr_ptr + PTR_ONE;
      if (bus.wr_last) begin
        lq_mem[lq_wr_ptr[P-1:0]] <= open_cnt_next;
        lq_wr_ptr                <= lq_wr_ptr + LQ_ONE;
        commit_ptr               <= wr_ptr + PTR_ONE;
        open_cnt                 <= '0;
      end else begin
        open_cnt <= open_cnt_next;
      end
    end
  end

  // Stage p0 -> p1: issue a RAM read only if the skid buffer can absorb it.
  assign skid_cnt_next = skid_cnt_p2 + {1'b0, inflight_p1} - {1'b0, rd_hs};
  assign rd_issue_p0   = (rd_ptr != commit_ptr) && !skid_cnt_next[1];

  always_ff @(posedge clk) begin
    if (wr_fire)     mem[wr_ptr[D-1:0]] <= bus.wr_data;
    if (rd_issue_p0) ram_q_p1           <= mem[rd_ptr[D-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      inflight_p1 <= 1'b0;
    end else begin
      inflight_p1 <= rd_issue_p0;
      if (rd_issue_p0) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Stage p1 -> p2: two-entry skid buffer, entry 0 is the output head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_cnt_p2     <= '0;
      skid_data_p2[0] <= '0;
      skid_data_p2[1] <= '0;
    end else begin
      skid_cnt_p2 <= skid_cnt_next;
      if (rd_hs) begin
        skid_data_p2[0] <= (skid_cnt_p2 == 2'd2) ? skid_data_p2[1] : ram_q_p1;
        skid_data_p2[1] <= ram_q_p1;
      end else if (inflight_p1) begin
        if (skid_cnt_p2 == 2'd0) skid_data_p2[0] <= ram_q_p1;
        else                     skid_data_p2[1] <= ram_q_p1;
      end
    end
  end

  assign rd_valid  = (skid_cnt_p2 != 2'd0);
  assign rd_hs     = rd_valid & bus.rd_ready;
  assign pkt_avail = (lq_cnt != '0);
  assign pkt_len   = pkt_avail ? lq_mem[lq_rd_ptr[P-1:0]] : '0;
  assign rd_last   = rd_valid && (beat_idx == pkt_len - PTR_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_ptr  <= '0;
      beat_idx  <= '0;
      lq_rd_ptr <= '0;
    end else if (rd_hs) begin
      free_ptr <= free_ptr + PTR_ONE;
      if (rd_last) begin
        beat_idx  <= '0;
        lq_rd_ptr <= lq_rd_ptr + LQ_ONE;
      end else begin
        beat_idx <= beat_idx + PTR_ONE;
      end
    end
  end

`ifdef PCIE_CQ_TX_FIFO_ERR_EN
  logic ovf_err;
  // An open packet that fills the whole queue can never commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
    end else if ((bus.wr_en && !full_n) ||
                 (wr_fire && !bus.wr_last && open_cnt_next[D])) begin
      ovf_err <= 1'b1;
    end
  end
  assign bus.ovf_err = ovf_err;
`else
  assign bus.ovf_err = 1'b0;
`endif

  assign bus.full_n    = full_n;
  assign bus.pkt_avail = pkt_avail;
  assign bus.pkt_len   = pkt_len;
  assign bus.rd_valid  = rd_valid;
  assign bus.rd_data   = skid_data_p2[0];
  assign bus.rd_last   = rd_last;
endmodule

// File: tb/tb_pcie_cq_tx_fifo.sv
// Directed bench for pcie_cq_tx_fifo: commit latency, partial packets, full
// conditions, length-queue limit, randomised wrap traffic and mid-run reset.
module tb_pcie_cq_tx_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

`ifdef PCIE_CQ_TX_FIFO_ERR_EN
  localparam bit EXP_OVF = 1'b1;
`else
  localparam bit EXP_OVF = 1'b0;
`endif

  always #5 clk = ~clk;

  pcie_cq_tx_fifo_if #(.P_FIFO_DATA_WIDTH(128), .P_FIFO_DEPTH_WIDTH(5)) bus ();

  pcie_cq_tx_fifo #(
    .P_FIFO_DATA_WIDTH (128),
    .P_FIFO_DEPTH_WIDTH(5),
    .P_PKT_DEPTH_WIDTH (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en    = 1'b0;
    bus.wr_data  = '0;
    bus.wr_last  = 1'b0;
    bus.rd_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic write_beat(input logic [127:0] d, input bit last);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    bus.wr_last = last;
    step();
    bus.wr_en   = 1'b0;
    bus.wr_last = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    total++; if (bus.full_n !== 1'b1)    begin bad++; $display("FAIL rst_full_n: got %b want 1", bus.full_n); end
    total++; if (bus.pkt_avail !== 1'b0) begin bad++; $display("FAIL rst_pkt_avail: got %b want 0", bus.pkt_avail); end
    total++; if (bus.pkt_len !== 6'd0)   begin bad++; $display("FAIL rst_pkt_len: got %0d want 0", bus.pkt_len); end
    total++; if (bus.rd_valid !== 1'b0)  begin bad++; $display("FAIL rst_rd_valid: got %b want 0", bus.rd_valid); end
    total++; if (bus.rd_data !== 128'd0) begin bad++; $display("FAIL rst_rd_data: got %h want 0", bus.rd_data); end
    total++; if (bus.rd_last !== 1'b0)   begin bad++; $display("FAIL rst_rd_last: got %b want 0", bus.rd_last); end
    total++; if (bus.ovf_err !== 1'b0)   begin bad++; $display("FAIL rst_ovf_err: got %b want 0", bus.ovf_err); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [127:0] exp_d [3];
    exp_d[0] = 128'hA; exp_d[1] = 128'hB; exp_d[2] = 128'hC;
    bus.rd_ready = 1'b1;
    write_beat(128'hA, 1'b0);
    write_beat(128'hB, 1'b0);
    total++; if (bus.pkt_avail !== 1'b0) begin bad++; $display("FAIL basic_open_avail: got %b want 0", bus.pkt_avail); end
    write_beat(128'hC, 1'b1);
    // after closing edge N
    total++; if (bus.pkt_avail !== 1'b1) begin bad++; $display("FAIL basic_avail: got %b want 1", bus.pkt_avail); end
    total++; if (bus.pkt_len !== 6'd3)   begin bad++; $display("FAIL basic_len: got %0d want 3", bus.pkt_len); end
    step();
    total++; if (bus.rd_valid !== 1'b0)  begin bad++; $display("FAIL basic_early_valid: got %b want 0", bus.rd_valid); end
    step();
    for (int k = 0; k < 3; k++) begin
      total++; if (bus.rd_valid !== 1'b1)      begin bad++; $display("FAIL basic_valid%0d: got %b want 1", k, bus.rd_valid); end
      total++; if (bus.rd_data !== exp_d[k])   begin bad++; $display("FAIL basic_data%0d: got %h want %h", k, bus.rd_data, exp_d[k]); end
      total++; if (bus.rd_last !== (k == 2))   begin bad++; $display("FAIL basic_last%0d: got %b want %b", k, bus.rd_last, (k == 2)); end
      step();
    end
    total++; if (bus.pkt_avail !== 1'b0) begin bad++; $display("FAIL basic_avail_after: got %b want 0", bus.pkt_avail); end
    total++; if (bus.rd_valid !== 1'b0)  begin bad++; $display("FAIL basic_valid_after: got %b want 0", bus.rd_valid); end
    bus.rd_ready = 1'b0;
  endtask

  task automatic test_partial();
    int got = 0;
    bus.rd_ready = 1'b1;
    write_beat(128'h20, 1'b0);
    write_beat(128'h21, 1'b0);
    for (int c = 0; c < 8; c++) begin
      total++; if (bus.pkt_avail !== 1'b0 || bus.rd_valid !== 1'b0) begin
        bad++; $display("FAIL partial_hidden: avail=%b valid=%b want 0/0", bus.pkt_avail, bus.rd_valid);
      end
      step();
    end
    write_beat(128'h22, 1'b1);
    total++; if (bus.pkt_len !== 6'd3) begin bad++; $display("FAIL partial_len: got %0d want 3", bus.pkt_len); end
    for (int c = 0; c < 12 && got < 3; c++) begin
      if (bus.rd_valid) begin
        total++; if (bus.rd_data !== 128'(32'h20 + got)) begin bad++; $display("FAIL partial_data%0d: got %h want %h", got, bus.rd_data, 32'h20 + got); end
        total++; if (bus.rd_last !== (got == 2))          begin bad++; $display("FAIL partial_last%0d: got %b want %b", got, bus.rd_last, (got == 2)); end
        got++;
      end
      step();
    end
    total++; if (got !== 3) begin bad++; $display("FAIL partial_count: got %0d want 3", got); end
    bus.rd_ready = 1'b0;
  endtask

  task automatic test_full();
    int got = 1;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      if (i == 31) begin
        total++; if (bus.full_n !== 1'b1) begin bad++; $display("FAIL full_before32: got %b want 1", bus.full_n); end
      end
      write_beat(128'(32'h100 + i), (i == 31));
    end
    total++; if (bus.full_n !== 1'b0)  begin bad++; $display("FAIL full_after32: got %b want 0", bus.full_n); end
    total++; if (bus.pkt_len !== 6'd32) begin bad++; $display("FAIL full_len: got %0d want 32", bus.pkt_len); end
    write_beat(128'hDEAD, 1'b0);
    total++; if (bus.ovf_err !== EXP_OVF) begin bad++; $display("FAIL full_ovf: got %b want %b", bus.ovf_err, EXP_OVF); end
    total++; if (bus.full_n !== 1'b0)     begin bad++; $display("FAIL full_still: got %b want 0", bus.full_n); end
    for (int c = 0; c < 8 && !bus.rd_valid; c++) step();
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 128'h100) begin
      bad++; $display("FAIL full_head: valid=%b data=%h want 1/100", bus.rd_valid, bus.rd_data);
    end
    bus.rd_ready = 1'b1;
    step();
    bus.rd_ready = 1'b0;
    total++; if (bus.full_n !== 1'b1) begin bad++; $display("FAIL full_freed: got %b want 1", bus.full_n); end
    bus.rd_ready = 1'b1;
    for (int c = 0; c < 100 && got < 32; c++) begin
      if (bus.rd_valid) begin
        total++; if (bus.rd_data !== 128'(32'h100 + got)) begin bad++; $display("FAIL full_data%0d: got %h want %h", got, bus.rd_data, 32'h100 + got); end
        total++; if (bus.rd_last !== (got == 31))          begin bad++; $display("FAIL full_last%0d: got %b want %b", got, bus.rd_last, (got == 31)); end
        got++;
      end
      step();
    end
    total++; if (got !== 32) begin bad++; $display("FAIL full_count: got %0d want 32", got); end
    total++; if (bus.rd_valid !== 1'b0 || bus.pkt_avail !== 1'b0) begin
      bad++; $display("FAIL full_empty: valid=%b avail=%b want 0/0", bus.rd_valid, bus.pkt_avail);
    end
    bus.rd_ready = 1'b0;
  endtask

  task automatic test_pkt_queue();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        total++; if (bus.full_n !== 1'b1) begin bad++; $display("FAIL pq_three: got %b want 1", bus.full_n); end
      end
      write_beat(128'(32'h11 + i), 1'b1);
    end
    total++; if (bus.full_n !== 1'b0) begin bad++; $display("FAIL pq_full: got %b want 0", bus.full_n); end
    step();
    step();
    bus.rd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total++; if (bus.rd_valid !== 1'b1)             begin bad++; $display("FAIL pq_valid%0d: got %b want 1", k, bus.rd_valid); end
      total++; if (bus.rd_data !== 128'(32'h11 + k))  begin bad++; $display("FAIL pq_data%0d: got %h want %h", k, bus.rd_data, 32'h11 + k); end
      total++; if (bus.rd_last !== 1'b1)              begin bad++; $display("FAIL pq_last%0d: got %b want 1", k, bus.rd_last); end
      total++; if (bus.pkt_len !== 6'd1)              begin bad++; $display("FAIL pq_len%0d: got %0d want 1", k, bus.pkt_len); end
      step();
    end
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL pq_drained: got %b want 0", bus.rd_valid); end
    bus.rd_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [127:0] exp_data [$];
    bit           exp_last [$];
    int           exp_len  [$];
    logic [127:0] d;
    int pkts_sent = 0, beat_in_pkt = 0, cycles = 0, cur_len;
    bit out_first = 1'b1;
    do_reset();
    cur_len = $urandom_range(1, 8);
    while ((pkts_sent < 100 || exp_data.size() != 0) && cycles < 20000) begin
      bus.rd_ready = ($urandom_range(0, 3) != 0);
      if (bus.rd_valid && bus.rd_ready) begin
        total++;
        if (exp_data.size() == 0) begin
          bad++; $display("FAIL rnd_extra: got beat %h want none", bus.rd_data);
        end else begin
          if (bus.rd_data !== exp_data[0]) begin bad++; $display("FAIL rnd_data: got %h want %h", bus.rd_data, exp_data[0]); end
          total++; if (bus.rd_last !== exp_last[0]) begin bad++; $display("FAIL rnd_last: got %b want %b", bus.rd_last, exp_last[0]); end
          if (out_first) begin
            total++; if (bus.pkt_len !== 6'(exp_len[0])) begin bad++; $display("FAIL rnd_len: got %0d want %0d", bus.pkt_len, exp_len[0]); end
          end
          out_first = exp_last[0];
          if (exp_last[0]) void'(exp_len.pop_front());
          void'(exp_data.pop_front());
          void'(exp_last.pop_front());
        end
      end
      bus.wr_en   = 1'b0;
      bus.wr_last = 1'b0;
      if (pkts_sent < 100 && bus.full_n && $urandom_range(0, 3) != 0) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        bus.wr_last = (beat_in_pkt == cur_len - 1);
        if (beat_in_pkt == 0) exp_len.push_back(cur_len);
        exp_data.push_back(d);
        exp_last.push_back(bus.wr_last);
        if (bus.wr_last) begin
          pkts_sent++;
          beat_in_pkt = 0;
          cur_len = $urandom_range(1, 8);
        end else begin
          beat_in_pkt++;
        end
      end
      step();
      cycles++;
    end
    idle_inputs();
    total++; if (exp_data.size() != 0) begin bad++; $display("FAIL rnd_timeout: got %0d beats left want 0", exp_data.size()); end
    total++; if (bus.ovf_err !== 1'b0)  begin bad++; $display("FAIL rnd_ovf: got %b want 0", bus.ovf_err); end
  endtask

  task automatic test_reset_mid();
    int got = 0;
    do_reset();
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) write_beat(128'(32'h51 + i), (i == 3));
    write_beat(128'h61, 1'b0);
    write_beat(128'h62, 1'b0);
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 128'h51) begin
      bad++; $display("FAIL mid_pre: valid=%b data=%h want 1/51", bus.rd_valid, bus.rd_data);
    end
    rst_n = 1'b0;
    #1;
    total++; if (bus.rd_valid !== 1'b0)  begin bad++; $display("FAIL mid_rd_valid: got %b want 0", bus.rd_valid); end
    total++; if (bus.rd_data !== 128'd0) begin bad++; $display("FAIL mid_rd_data: got %h want 0", bus.rd_data); end
    total++; if (bus.rd_last !== 1'b0)   begin bad++; $display("FAIL mid_rd_last: got %b want 0", bus.rd_last); end
    total++; if (bus.pkt_avail !== 1'b0) begin bad++; $display("FAIL mid_avail: got %b want 0", bus.pkt_avail); end
    total++; if (bus.pkt_len !== 6'd0)   begin bad++; $display("FAIL mid_len: got %0d want 0", bus.pkt_len); end
    total++; if (bus.full_n !== 1'b1)    begin bad++; $display("FAIL mid_full_n: got %b want 1", bus.full_n); end
    step();
    rst_n = 1'b1;
    step();
    write_beat(128'h77, 1'b0);
    write_beat(128'h78, 1'b1);
    total++; if (bus.pkt_len !== 6'd2) begin bad++; $display("FAIL mid_new_len: got %0d want 2", bus.pkt_len); end
    for (int c = 0; c < 10 && got < 3; c++) begin
      if (bus.rd_valid) begin
        total++; if (got < 2 && bus.rd_data !== 128'(32'h77 + got)) begin bad++; $display("FAIL mid_new_data%0d: got %h want %h", got, bus.rd_data, 32'h77 + got); end
        total++; if (got < 2 && bus.rd_last !== (got == 1))          begin bad++; $display("FAIL mid_new_last%0d: got %b want %b", got, bus.rd_last, (got == 1)); end
        got++;
      end
      step();
    end
    total++; if (got !== 2) begin bad++; $display("FAIL mid_new_count: got %0d want 2", got); end
    bus.rd_ready = 1'b0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_partial();
    test_full();
    test_pkt_queue();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
